// File: rtl/delay_buffer_mc.sv
// Multi-lane delay line with a runtime-selectable delay, fill tracking and flush.
// Define DLY_PARITY_EN to store a per-lane parity bit and flag sticky read-side errors.
module delay_buffer_mc #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int BITS     = 64,
  localparam int DW      = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic [DW-1:0]            delay_sel,
  input  logic [CHANNELS*BITS-1:0] d,
  output logic [CHANNELS*BITS-1:0] q,
  output logic                     q_valid,
  output logic [DW-1:0]            fill,
  output logic [CHANNELS-1:0]      par_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int W  = CHANNELS * BITS;
  localparam logic [DW-1:0] DEPTH_DW = DW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [DW:0]   DEPTH_X  = (DW+1)'(DEPTH);

  // Valid/ready: none. A sample is accepted on every rising edge with en=1 and
  // flush=0; q is meaningful only while q_valid=1 and reads as zero otherwise.

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]   fill_q, fill_d;
  logic [DW-1:0]   eff_delay;
  logic [DW:0]     ptr_x, dly_x, rd_sum;
  logic [PW-1:0]   rd_idx;
  logic [W-1:0]    rd_word;
  logic            push;

  assign push = en && !flush;

  always_comb begin
    eff_delay = delay_sel;
    if (delay_sel == '0) begin
      eff_delay = DW'(1);
    end else if (delay_sel > DEPTH_DW) begin
      eff_delay = DEPTH_DW;
    end
  end

  // Modular subtraction with an explicit +DEPTH correction, so DEPTH need not be a power of two.
  always_comb begin
    ptr_x = (DW+1)'(wr_ptr_q);
    dly_x = {1'b0, eff_delay};
    if (ptr_x >= dly_x) begin
      rd_sum = ptr_x - dly_x;
    end else begin
      rd_sum = ptr_x + DEPTH_X - dly_x;
    end
    rd_idx = rd_sum[PW-1:0];
  end

  assign rd_word = mem_q[rd_idx];
  assign q_valid = (fill_q >= eff_delay);
  assign q       = q_valid ? rd_word : '0;
  assign fill    = fill_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (flush) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (en) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (fill_q != DEPTH_DW) begin
        fill_d = fill_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage is deliberately unreset; stale entries are hidden by q_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= d;
    end
  end

`ifdef DLY_PARITY_EN
  logic [CHANNELS-1:0] par_mem_q [DEPTH];
  logic [CHANNELS-1:0] par_err_q, par_err_d;
  logic [CHANNELS-1:0] din_par, rd_par, rd_bad;

  always_comb begin
    din_par = '0;
    rd_par  = par_mem_q[rd_idx];
    rd_bad  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      din_par[i] = ^d[i*BITS +: BITS];
      rd_bad[i]  = (^rd_word[i*BITS +: BITS]) != rd_par[i];
    end
  end

  always_comb begin
    par_err_d = par_err_q;
    if (flush) begin
      par_err_d = '0;
    end else if (q_valid) begin
      par_err_d = par_err_q | rd_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      par_mem_q[wr_ptr_q] <= din_par;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= '0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = '0;
`endif

endmodule

// File: tb/tb_delay_buffer_mc.sv
// Directed bench for delay_buffer_mc: default 4x16x64 instance plus a 2x12x8 instance
// that exercises the non-power-of-two pointer wrap.
module tb_delay_buffer_mc;

  logic         clk;
  logic         rst_n;
  logic         en, flush;
  logic [4:0]   delay_sel;
  logic [255:0] d, q;
  logic         q_valid;
  logic [4:0]   fill;
  logic [3:0]   par_err;

  logic         en12;
  logic [3:0]   delay_sel12;
  logic [15:0]  d12, q12;
  logic         q_valid12;
  logic [3:0]   fill12;
  logic [1:0]   par_err12;

  int checks;
  int failures;

  delay_buffer_mc u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .delay_sel(delay_sel),
    .d(d), .q(q), .q_valid(q_valid), .fill(fill), .par_err(par_err)
  );

  delay_buffer_mc #(.CHANNELS(2), .DEPTH(12), .BITS(8)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .en(en12), .flush(1'b0), .delay_sel(delay_sel12),
    .d(d12), .q(q12), .q_valid(q_valid12), .fill(fill12), .par_err(par_err12)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // lane i carries base + i*step
  function automatic logic [255:0] lanes(input int base, input int step);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*64 +: 64] = 64'(base + i * step);
    return v;
  endfunction

  function automatic logic [15:0] lanes12(input int v);
    return {8'(v + 100), 8'(v)};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push(input logic [255:0] data);
    d  = data;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic push12(input logic [15:0] data);
    d12  = data;
    en12 = 1'b1;
    @(posedge clk);
    #1;
    en12 = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [255:0] data,
                           input int fl);
    check({tag, "_valid"}, 256'(q_valid), 256'(vld));
    check({tag, "_q"}, q, vld ? data : '0);
    check({tag, "_fill"}, 256'(fill), 256'(fl));
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; delay_sel = 5'd3; d = '0;
    en12 = 1'b0; delay_sel12 = 4'd12; d12 = '0;

    // reset state
    #12;
    check("rst_valid", 256'(q_valid), 256'(0));
    check("rst_q", q, '0);
    check("rst_fill", 256'(fill), 256'(0));
    check("rst_par_err", 256'(par_err), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // delay 3, 20 pushes: valid from the third push, fill saturates at 16
    for (int n = 0; n < 20; n++) begin
      push(lanes(n, 16));
      check_out($sformatf("d3_n%0d", n), n >= 2, lanes(n - 2, 16), (n + 1 > 16) ? 16 : n + 1);
    end

    // flush with a simultaneous push of 0xAA: flush wins, sample dropped
    flush = 1'b1;
    push(lanes(32'hAA, 0));
    flush = 1'b0;
    check_out("flush_en", 1'b0, '0, 0);
    check("flush_par_err", 256'(par_err), 256'(0));

    // full depth delay, 40 pushes, pointer wraps twice
    delay_sel = 5'd16;
    for (int n = 0; n < 40; n++) begin
      push(lanes(1000 + n, 7));
      check_out($sformatf("d16_n%0d", n), n >= 15, lanes(1000 + n - 15, 7),
                (n + 1 > 16) ? 16 : n + 1);
    end

    // clamping: 0 acts as 1, 31 acts as 16, applied combinationally
    delay_sel = 5'd0;
    #1;
    check_out("sel0", 1'b1, lanes(1039, 7), 16);
    delay_sel = 5'd31;
    #1;
    check_out("sel31", 1'b1, lanes(1024, 7), 16);
    delay_sel = 5'd1;
    #1;
    check_out("sel1", 1'b1, lanes(1039, 7), 16);
    delay_sel = 5'd0;
    push(lanes(1040, 7));
    check_out("sel0_push", 1'b1, lanes(1040, 7), 16);

    // delay change mid-stream and en=0 hold
    flush = 1'b1;
    idle();
    flush = 1'b0;
    check_out("flush_idle", 1'b0, '0, 0);
    delay_sel = 5'd2;
    for (int n = 0; n < 5; n++) begin
      push(lanes(2000 + n, 3));
      check_out($sformatf("d2_n%0d", n), n >= 1, lanes(2000 + n - 1, 3), n + 1);
    end
    delay_sel = 5'd8;
    #1;
    check_out("d8_drop", 1'b0, '0, 5);
    for (int n = 5; n < 8; n++) begin
      push(lanes(2000 + n, 3));
      check_out($sformatf("d8_n%0d", n), n >= 7, lanes(2000, 3), n + 1);
    end
    idle();
    check_out("hold1", 1'b1, lanes(2000, 3), 8);
    idle();
    check_out("hold2", 1'b1, lanes(2000, 3), 8);
    delay_sel = 5'd3;
    #1;
    check_out("hold_sel3", 1'b1, lanes(2005, 3), 8);
    delay_sel = 5'd8;
    push(lanes(2008, 3));
    check_out("d8_n8", 1'b1, lanes(2001, 3), 9);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, '0, 0);
    check("async_rst_par_err", 256'(par_err), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    delay_sel = 5'd1;
    push(lanes(3000, 5));
    check_out("post_rst", 1'b1, lanes(3000, 5), 1);

    // DEPTH=12 instance: non-power-of-two wrap
    for (int n = 0; n < 30; n++) begin
      push12(lanes12(n));
      check($sformatf("dp12_valid_n%0d", n), 256'(q_valid12), 256'(n >= 11));
      check($sformatf("dp12_q_n%0d", n), 256'(q12), 256'((n >= 11) ? lanes12(n - 11) : 16'h0));
      check($sformatf("dp12_fill_n%0d", n), 256'(fill12), 256'((n + 1 > 12) ? 12 : n + 1));
    end
    delay_sel12 = 4'd15;
    #1;
    check("dp12_sel15", 256'(q12), 256'(lanes12(18)));
    delay_sel12 = 4'd5;
    #1;
    check("dp12_sel5", 256'(q12), 256'(lanes12(25)));
    check("dp12_par_err", 256'(par_err12), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
